// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - control/sample bundle between mux_scan_ctrl and its mux/host side
// Optional MUX_SCAN_MASK_EN adds the ch_mask_i channel-enable field.
interface mux_scan_ctrl_if;
  logic       start_i;
  logic       d_i;
  logic       s1_o;
  logic       s0_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] word_o;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0] ch_mask_i;
`endif

  modport master (
    input  start_i, d_i,
`ifdef MUX_SCAN_MASK_EN
    input  ch_mask_i,
`endif
    output s1_o, s0_o, busy_o, done_o, word_o
  );

  modport slave (
    output start_i, d_i,
`ifdef MUX_SCAN_MASK_EN
    output ch_mask_i,
`endif
    input  s1_o, s0_o, busy_o, done_o, word_o
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps a 4:1 mux select, dwells, samples D into a 4-bit word
// Optional MUX_SCAN_MASK_EN: per-channel enable mask latched at start.
module mux_scan_ctrl #(
  parameter int DWELL   = 2,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_scan_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [DWELL_W-1:0] CNT_RELOAD = DWELL_W'(DWELL - 1);

  state_t             state_q;
  logic [1:0]         ch_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         word_q;
  logic [3:0]         mask_run;
  logic [3:0]         mask_new;
  logic [2:0]         first_ch_d;
  logic [2:0]         next_ch_d;

`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mask_q;
  assign mask_run = mask_q;
  assign mask_new = bus.ch_mask_i;
`else
  assign mask_run = 4'hF;
  assign mask_new = 4'hF;
`endif

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [2:0] find_en(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_ch_d = find_en(mask_new, 3'd0);
    next_ch_d  = find_en(mask_run, {1'b0, ch_q} + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= 4'd0;
`ifdef MUX_SCAN_MASK_EN
      mask_q  <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            word_q <= 4'd0;
`ifdef MUX_SCAN_MASK_EN
            mask_q <= bus.ch_mask_i;
`endif
            if (first_ch_d[2]) begin
              state_q <= SCAN;
              ch_q    <= first_ch_d[1:0];
              cnt_q   <= CNT_RELOAD;
              busy_q  <= 1'b1;
            end else begin
              // Nothing enabled: report an empty word straight away.
              state_q <= DONE;
              ch_q    <= 2'd0;
              done_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            word_q[ch_q] <= bus.d_i;
            if (next_ch_d[2]) begin
              ch_q  <= next_ch_d[1:0];
              cnt_q <= CNT_RELOAD;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ch_q    <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
          ch_q    <= 2'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1_o   = ch_q[1];
  assign bus.s0_o   = ch_q[0];
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.word_o = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - table-driven bench for mux_scan_ctrl with a 4:1 mux model
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;
  logic [3:0] in_a;
  logic [3:0] in_b;
  int n_chk;
  int n_fail;

  mux_scan_ctrl_if bus_a ();
  mux_scan_ctrl_if bus_b ();

  mux_scan_ctrl #(.DWELL(2), .DWELL_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_scan_ctrl #(.DWELL(1), .DWELL_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.d_i = in_a[{bus_a.s1_o, bus_a.s0_o}];
  assign bus_b.d_i = in_b[{bus_b.s1_o, bus_b.s0_o}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic [3:0] mux;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [3:0] m,
                     input logic [1:0] sel, input logic b, input logic d, input logic [3:0] w);
    vec_t v;
    v.rst_n = r; v.start = s; v.mux = m; v.sel = sel; v.busy = b; v.done = d; v.word = w;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_a = 4'b1010;
    in_b = 4'b0110;
    bus_a.start_i = 1'b1;
    bus_b.start_i = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    bus_a.ch_mask_i = 4'hF;
    bus_b.ch_mask_i = 4'b1010;
`endif

    // reset with start/D active, then idle
    add(0, 1, 4'b1010, 2'b00, 0, 0, 4'b0000);
    add(0, 1, 4'b1010, 2'b00, 0, 0, 4'b0000);
    add(1, 0, 4'b1010, 2'b00, 0, 0, 4'b0000);
    add(1, 0, 4'b1010, 2'b00, 0, 0, 4'b0000);
    // basic scan, second start at ch=1 ignored
    add(1, 1, 4'b1010, 2'b00, 1, 0, 4'b0000);
    add(1, 0, 4'b1010, 2'b00, 1, 0, 4'b0000);
    add(1, 0, 4'b1010, 2'b01, 1, 0, 4'b0000);
    add(1, 1, 4'b1010, 2'b01, 1, 0, 4'b0000);
    add(1, 0, 4'b1010, 2'b10, 1, 0, 4'b0010);
    add(1, 0, 4'b1010, 2'b10, 1, 0, 4'b0010);
    add(1, 0, 4'b1010, 2'b11, 1, 0, 4'b0010);
    add(1, 0, 4'b1010, 2'b11, 1, 0, 4'b0010);
    add(1, 0, 4'b1010, 2'b11, 0, 1, 4'b1010);
    add(1, 0, 4'b1010, 2'b00, 0, 0, 4'b1010);
    add(1, 0, 4'b1010, 2'b00, 0, 0, 4'b1010);
    // continuous start, new mux inputs
    add(1, 1, 4'b0101, 2'b00, 1, 0, 4'b0000);
    add(1, 1, 4'b0101, 2'b00, 1, 0, 4'b0000);
    add(1, 1, 4'b0101, 2'b01, 1, 0, 4'b0001);
    add(1, 1, 4'b0101, 2'b01, 1, 0, 4'b0001);
    add(1, 1, 4'b0101, 2'b10, 1, 0, 4'b0001);
    add(1, 1, 4'b0101, 2'b10, 1, 0, 4'b0001);
    add(1, 1, 4'b0101, 2'b11, 1, 0, 4'b0101);
    add(1, 1, 4'b0101, 2'b11, 1, 0, 4'b0101);
    add(1, 1, 4'b0101, 2'b11, 0, 1, 4'b0101);
    add(1, 1, 4'b0101, 2'b00, 0, 0, 4'b0101);
    add(1, 1, 4'b0101, 2'b00, 1, 0, 4'b0000);
    add(1, 0, 4'b0101, 2'b00, 1, 0, 4'b0000);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      bus_a.start_i = vecs[i].start;
      in_a = vecs[i].mux;
      step();
      chk($sformatf("v%0d sel", i), {30'd0, bus_a.s1_o, bus_a.s0_o}, {30'd0, vecs[i].sel});
      chk($sformatf("v%0d busy", i), {31'd0, bus_a.busy_o}, {31'd0, vecs[i].busy});
      chk($sformatf("v%0d done", i), {31'd0, bus_a.done_o}, {31'd0, vecs[i].done});
      chk($sformatf("v%0d word", i), {28'd0, bus_a.word_o}, {28'd0, vecs[i].word});
    end

    // mid-scan asynchronous reset
    repeat (3) step();
    chk("pre_reset sel", {30'd0, bus_a.s1_o, bus_a.s0_o}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst sel", {30'd0, bus_a.s1_o, bus_a.s0_o}, 32'd0);
    chk("async_rst busy", {31'd0, bus_a.busy_o}, 32'd0);
    chk("async_rst word", {28'd0, bus_a.word_o}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("post_rst%0d done", i), {31'd0, bus_a.done_o}, 32'd0);
      chk($sformatf("post_rst%0d busy", i), {31'd0, bus_a.busy_o}, 32'd0);
    end

    // DWELL=1 instance
    begin
`ifdef MUX_SCAN_MASK_EN
      logic [1:0] es[3] = '{2'd1, 2'd3, 2'd3};
      logic       eb[3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0] ew[3] = '{4'b0000, 4'b0010, 4'b0010};
      int n = 3;
`else
      logic [1:0] es[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      logic       eb[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0] ew[5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0110, 4'b0110};
      int n = 5;
`endif
      bus_b.start_i = 1'b1;
      for (int i = 0; i < n; i++) begin
        step();
        bus_b.start_i = 1'b0;
        chk($sformatf("b%0d sel", i), {30'd0, bus_b.s1_o, bus_b.s0_o}, {30'd0, es[i]});
        chk($sformatf("b%0d busy", i), {31'd0, bus_b.busy_o}, {31'd0, eb[i]});
        chk($sformatf("b%0d done", i), {31'd0, bus_b.done_o}, {31'd0, (i == n - 1) ? 1'b1 : 1'b0});
        chk($sformatf("b%0d word", i), {28'd0, bus_b.word_o}, {28'd0, ew[i]});
      end
      step();
      chk("b_idle sel", {30'd0, bus_b.s1_o, bus_b.s0_o}, 32'd0);
      chk("b_idle done", {31'd0, bus_b.done_o}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
